int_entry_seq: RTL and testbench
================================

# int_entry_seq

Interrupt-entry sequencer between the interrupt unit and the CPU core. At an instruction boundary it accepts a reset, NMI or GIE-enabled maskable request. It then drives the memory bus and register-load strobes through the fixed MSP430 entry sequence: push PC, push SR, acknowledge, clear SR, fetch vector, load PC. While the sequence runs it holds the core off with `Busy`; `INTACK` is the strobe that clears the winning flag in the interrupt unit.

## Interface
Parameters:
- `VEC_BASE`, 16'hFF80: base address of the 64-entry vector table; vector address = `VEC_BASE | {IntAddrLSBs,1'b0}`.
- `SR_KEEP_MASK`, 16'h0040: SR bits preserved on entry (SCG0); all other bits are cleared.

Ports:
- `MCLK`  in  1  system clock; all state updates on the rising edge.
- `RSTn`  in  1  reset; synchronous, active-low.
- `reset`  in  1  device reset request from the interrupt unit (level).
- `NMI`  in  1  non-maskable request (level).
- `INT`  in  1  maskable request (level).
- `IntAddrLSBs`  in  6  winning vector index from the interrupt unit.
- `InstrBoundary`  in  1  core is between instructions.
- `PC`, `SR`, `SP`  in  16 each  current core registers.
- `MDBin`  in  16  memory read data, valid the cycle after `MR`.
- `Busy`  out  1  stall the core; sequence in progress.
- `INTACK`  out  1  one-cycle acknowledge to the interrupt unit.
- `MAB`  out  16  memory address.
- `MDBout`  out  16  memory write data.
- `MW`  out  1  word write strobe.
- `MR`  out  1  word read strobe.
- `PC_load`  out  1  core loads `PC_next` this edge.
- `PC_next`  out  16  value for `PC_load`.
- `SR_load`  out  1  core loads `SR_next` this edge.
- `SR_next`  out  16  value for `SR_load`.
- `SP_load`  out  1  core loads `SP_next` this edge.
- `SP_next`  out  16  value for `SP_load`.

## Operation
States: `IDLE`, `PUSH_PC`, `PUSH_SR`, `ACK`, `VEC`, `LOAD`, `RST_HOLD`, `RST_VEC`, `RST_LOAD`.
- **`IDLE`**: `Busy`=0.
  - If `reset` is high, go to `RST_HOLD`. This path has priority over every other request and does not wait for `InstrBoundary`.
  - Else, if `InstrBoundary` && (`NMI` || `INT` && `SR[3]`), capture `pc_q`=`PC`, `sr_q`=`SR`, `sp_q`=`SP` and go to `PUSH_PC`.
  - Requests without `InstrBoundary` are ignored. They stay pending because they are levels.
- **`PUSH_PC`**: `MAB`=`sp_q`-2, `MDBout`=`pc_q`, `MW`=1.
- **`PUSH_SR`**: `MAB`=`sp_q`-4, `MDBout`=`sr_q`, `MW`=1.
- **`ACK`**:
  - `INTACK`=1; latch `vec_q`=`IntAddrLSBs`. The priority winner is taken here, not at acceptance.
  - `SR_load`=1 with `SR_next`=`sr_q` & `SR_KEEP_MASK`.
  - `SP_load`=1 with `SP_next`=`sp_q`-4.
- **`VEC`**: `MR`=1, `MAB`=`VEC_BASE` | {`vec_q`,1'b0}.
- **`LOAD`**: `PC_load`=1, `PC_next`=`MDBin`. Go to `IDLE`.
- **`RST_HOLD`**: `Busy`=1, no bus activity. Stay while `reset`=1; on `reset`=0 go to `RST_VEC`.
- **`RST_VEC`**: `MR`=1, `MAB`=`VEC_BASE`|16'h007E (0xFFFE), `INTACK`=1.
- **`RST_LOAD`**: `PC_load`=1 with `PC_next`=`MDBin`; `SR_load`=1 with `SR_next`=0. Go to `IDLE`.
- **Outputs**: strobes not listed for a state are 0. `MAB`, `MDBout` and the `*_next` outputs are 0 when their strobe is 0.
- **Address arithmetic**: 16-bit modulo 2^16. `sp_q`=0x0002 pushes to 0x0000 then 0xFFFE; no error is flagged.
- **`NMI`** is not gated by GIE. If the request drops before `ACK`, the sequence still completes using the `IntAddrLSBs` value present at `ACK`.
- **`reset` mid-sequence**: if `reset` is sampled high in any non-reset state, the next state is `RST_HOLD`. Writes in flight are abandoned, and no `PC_load`/`SR_load` is issued for the aborted entry.
- **`RSTn`=0**: next state `IDLE`; `vec_q`, `pc_q`, `sr_q`, `sp_q` go to 0. `RSTn` takes priority over `reset`.

## Timing
- **Reset values**: after `RSTn` all outputs are 0, including `Busy`.
- **Maskable/NMI entry**: acceptance edge at cycle A, then `PUSH_PC`=A+1, `PUSH_SR`=A+2, `ACK`=A+3, `VEC`=A+4, `LOAD`=A+5.
  - `Busy`=1 for cycles A+1..A+5 (5 cycles).
  - The core executes its first ISR fetch at A+6, six cycles after acceptance.
  - `INTACK` is high only in cycle A+3.
- **Back-to-back**: a new request can be accepted in the first `IDLE` cycle after `LOAD` if `InstrBoundary`=1. It is normally blocked because GIE is now clear.
- **Reset exit**: `RST_VEC` is the first cycle after `reset` falls, `RST_LOAD` is the next, and `IDLE` follows.

## Test plan
- **Power-up**: `RSTn`=0 for 2 cycles, `reset`=1 for 3 cycles, memory[0xFFFE]=0x4400.
  - Expect `RST_VEC` `MAB`=0xFFFE with `INTACK`=1.
  - Then `PC_load` with 0x4400 and `SR_load` with 0.
  - `Busy` high through `RST_LOAD`.
- **Maskable entry**: `INT`=1, `IntAddrLSBs`=52, `SR`=0x004B, `SP`=0x3000, `PC`=0x4420, `InstrBoundary`=1.
  - Expect `MW` to 0x2FFE/0x4420, then `MW` to 0x2FFC/0x004B.
  - Then `INTACK` with `SR_next`=0x0040 and `SP_next`=0x2FFC.
  - Then `MR` at 0xFFE8, then `PC_load`.
- **Masking**: `INT`=1 with `SR[3]`=0 for 10 cycles → `Busy` stays 0.
  - Same with `NMI`=1 → entry starts the next cycle.
- **Late priority change**: `INT` accepted with `IntAddrLSBs`=45; switch to 52 before `ACK` → vector fetch at 0xFFE8.
- **Abort**: assert `reset` during `PUSH_SR` → no `SR_load`/`PC_load` for the entry.
  - `RST_HOLD` until `reset` falls, then fetch from 0xFFFE.
- **Boundary gating**: `INT`=1 with `InstrBoundary`=0 for 4 cycles, then 1 → acceptance on that cycle, `INTACK` exactly 3 cycles later.

Source files
------------

// File: rtl/int_entry_seq.sv
// Interrupt-entry sequencer: pushes PC/SR, acknowledges the winner, fetches the
// vector and loads PC; also runs the reset-vector fetch after a device reset.
module int_entry_seq #(
  parameter logic [15:0] VEC_BASE     = 16'hFF80,
  parameter logic [15:0] SR_KEEP_MASK = 16'h0040
) (
  input  logic        MCLK,
  input  logic        RSTn,
  input  logic        reset,
  input  logic        NMI,
  input  logic        INT,
  input  logic [5:0]  IntAddrLSBs,
  input  logic        InstrBoundary,
  input  logic [15:0] PC,
  input  logic [15:0] SR,
  input  logic [15:0] SP,
  input  logic [15:0] MDBin,
  output logic        Busy,
  output logic        INTACK,
  output logic [15:0] MAB,
  output logic [15:0] MDBout,
  output logic        MW,
  output logic        MR,
  output logic        PC_load,
  output logic [15:0] PC_next,
  output logic        SR_load,
  output logic [15:0] SR_next,
  output logic        SP_load,
  output logic [15:0] SP_next
);

  // state    | meaning
  // IDLE     | waiting for reset or an accepted request at an instruction boundary
  // PUSH_PC  | write saved PC to SP-2
  // PUSH_SR  | write saved SR to SP-4
  // ACK      | INTACK, latch vector index, clear SR, commit SP-4
  // VEC      | read vector word
  // LOAD     | load PC from vector word
  // RST_HOLD | device reset asserted, core held
  // RST_VEC  | read reset vector at 0xFFFE, acknowledge
  // RST_LOAD | load PC from reset vector, clear SR
  typedef enum logic [3:0] {
    IDLE, PUSH_PC, PUSH_SR, ACK, VEC, LOAD, RST_HOLD, RST_VEC, RST_LOAD
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] sr_q, sr_d;
  logic [15:0] sp_q, sp_d;
  logic [5:0]  vec_q, vec_d;

  always_ff @(posedge MCLK) begin
    if (!RSTn) begin
      state_q <= IDLE;
      pc_q    <= 16'h0000;
      sr_q    <= 16'h0000;
      sp_q    <= 16'h0000;
      vec_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sr_q    <= sr_d;
      sp_q    <= sp_d;
      vec_q   <= vec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sr_d    = sr_q;
    sp_d    = sp_q;
    vec_d   = vec_q;
    Busy    = 1'b0;
    INTACK  = 1'b0;
    MAB     = 16'h0000;
    MDBout  = 16'h0000;
    MW      = 1'b0;
    MR      = 1'b0;
    PC_load = 1'b0;
    PC_next = 16'h0000;
    SR_load = 1'b0;
    SR_next = 16'h0000;
    SP_load = 1'b0;
    SP_next = 16'h0000;

    case (state_q)
      IDLE: begin
        if (reset) begin
          state_d = RST_HOLD;
        end else if (InstrBoundary && (NMI || (INT && SR[3]))) begin
          pc_d    = PC;
          sr_d    = SR;
          sp_d    = SP;
          state_d = PUSH_PC;
        end
      end
      // In entry states a sampled reset abandons the cycle's bus/load activity.
      PUSH_PC: begin
        Busy = 1'b1;
        if (reset) begin
          state_d = RST_HOLD;
        end else begin
          MW      = 1'b1;
          MAB     = sp_q - 16'd2;
          MDBout  = pc_q;
          state_d = PUSH_SR;
        end
      end
      PUSH_SR: begin
        Busy = 1'b1;
        if (reset) begin
          state_d = RST_HOLD;
        end else begin
          MW      = 1'b1;
          MAB     = sp_q - 16'd4;
          MDBout  = sr_q;
          state_d = ACK;
        end
      end
      ACK: begin
        Busy = 1'b1;
        if (reset) begin
          state_d = RST_HOLD;
        end else begin
          INTACK  = 1'b1;
          vec_d   = IntAddrLSBs;
          SR_load = 1'b1;
          SR_next = sr_q & SR_KEEP_MASK;
          SP_load = 1'b1;
          SP_next = sp_q - 16'd4;
          state_d = VEC;
        end
      end
      VEC: begin
        Busy = 1'b1;
        if (reset) begin
          state_d = RST_HOLD;
        end else begin
          MR      = 1'b1;
          MAB     = VEC_BASE | {9'd0, vec_q, 1'b0};
          state_d = LOAD;
        end
      end
      LOAD: begin
        Busy = 1'b1;
        if (reset) begin
          state_d = RST_HOLD;
        end else begin
          PC_load = 1'b1;
          PC_next = MDBin;
          state_d = IDLE;
        end
      end
      RST_HOLD: begin
        Busy = 1'b1;
        if (!reset) state_d = RST_VEC;
      end
      RST_VEC: begin
        Busy    = 1'b1;
        MR      = 1'b1;
        MAB     = VEC_BASE | 16'h007E;
        INTACK  = 1'b1;
        state_d = RST_LOAD;
      end
      RST_LOAD: begin
        Busy    = 1'b1;
        PC_load = 1'b1;
        PC_next = MDBin;
        SR_load = 1'b1;
        SR_next = 16'h0000;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_int_entry_seq.sv
// Directed bench for int_entry_seq: core/interrupt-unit stimulus plus a small
// registered vector memory; every cycle's outputs compared to hand values.
`timescale 1ns/1ps
module tb_int_entry_seq;

  logic        MCLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        reset = 1'b0;
  logic        NMI = 1'b0;
  logic        INT = 1'b0;
  logic [5:0]  IntAddrLSBs = 6'd0;
  logic        InstrBoundary = 1'b0;
  logic [15:0] PC = 16'h0000;
  logic [15:0] SR = 16'h0000;
  logic [15:0] SP = 16'h0000;
  logic [15:0] MDBin = 16'h0000;
  logic        Busy, INTACK, MW, MR, PC_load, SR_load, SP_load;
  logic [15:0] MAB, MDBout, PC_next, SR_next, SP_next;

  int n_checks = 0;
  int n_errors = 0;

  int_entry_seq dut (
    .MCLK(MCLK), .RSTn(RSTn), .reset(reset), .NMI(NMI), .INT(INT),
    .IntAddrLSBs(IntAddrLSBs), .InstrBoundary(InstrBoundary),
    .PC(PC), .SR(SR), .SP(SP), .MDBin(MDBin),
    .Busy(Busy), .INTACK(INTACK), .MAB(MAB), .MDBout(MDBout),
    .MW(MW), .MR(MR), .PC_load(PC_load), .PC_next(PC_next),
    .SR_load(SR_load), .SR_next(SR_next), .SP_load(SP_load), .SP_next(SP_next)
  );

  always #5 MCLK = ~MCLK;

  function automatic logic [15:0] mem_rd(input logic [15:0] addr);
    case (addr)
      16'hFFFE: mem_rd = 16'h4400;
      16'hFFE8: mem_rd = 16'h5000;
      16'hFFDA: mem_rd = 16'h6000;
      16'hFFFC: mem_rd = 16'h7000;
      default:  mem_rd = 16'hDEAD;
    endcase
  endfunction

  // read data appears the cycle after MR
  always @(posedge MCLK) MDBin <= MR ? mem_rd(MAB) : 16'h0000;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge MCLK);
    #2;
  endtask

  // full output bundle of the current cycle
  task automatic chk_all(input string tag, input logic busy, input logic ack,
                         input logic [15:0] mab, input logic [15:0] mdo,
                         input logic mw, input logic mr,
                         input logic pcl, input logic [15:0] pcn,
                         input logic srl, input logic [15:0] srn,
                         input logic spl, input logic [15:0] spn);
    chk({tag, ".Busy"}, Busy, busy);
    chk({tag, ".INTACK"}, INTACK, ack);
    chk({tag, ".MAB"}, MAB, mab);
    chk({tag, ".MDBout"}, MDBout, mdo);
    chk({tag, ".MW"}, MW, mw);
    chk({tag, ".MR"}, MR, mr);
    chk({tag, ".PC_load"}, PC_load, pcl);
    chk({tag, ".PC_next"}, PC_next, pcn);
    chk({tag, ".SR_load"}, SR_load, srl);
    chk({tag, ".SR_next"}, SR_next, srn);
    chk({tag, ".SP_load"}, SP_load, spl);
    chk({tag, ".SP_next"}, SP_next, spn);
  endtask

  task automatic chk_idle(input string tag);
    chk_all(tag, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
  endtask

  initial begin
    // power-up: RSTn low 2 cycles while reset is already requested
    reset = 1'b1;
    step(); step();
    chk_idle("rstn");
    RSTn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("rst_hold", 1, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    end
    reset = 1'b0;
    step();
    chk_all("rst_vec", 1, 1, 16'hFFFE, 16'h0, 0, 1, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    step();
    chk_all("rst_load", 1, 0, 16'h0, 16'h0, 0, 0, 1, 16'h4400, 1, 16'h0000, 0, 16'h0);
    step();
    chk_idle("rst_idle");

    // maskable entry
    PC = 16'h4420; SR = 16'h004B; SP = 16'h3000;
    IntAddrLSBs = 6'd52; INT = 1'b1; InstrBoundary = 1'b1;
    step();
    chk_all("m_push_pc", 1, 0, 16'h2FFE, 16'h4420, 1, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    step();
    chk_all("m_push_sr", 1, 0, 16'h2FFC, 16'h004B, 1, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    step();
    chk_all("m_ack", 1, 1, 16'h0, 16'h0, 0, 0, 0, 16'h0, 1, 16'h0040, 1, 16'h2FFC);
    SR = 16'h0040; SP = 16'h2FFC;
    step();
    chk_all("m_vec", 1, 0, 16'hFFE8, 16'h0, 0, 1, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    step();
    chk_all("m_load", 1, 0, 16'h0, 16'h0, 0, 0, 1, 16'h5000, 0, 16'h0, 0, 16'h0);
    step();
    chk_idle("m_idle");
    // back-to-back: INT still high but GIE now clear
    step();
    chk("b2b_blocked", Busy, 1'b0);

    // masking: GIE clear for 10 cycles
    SR = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("masked_busy", Busy, 1'b0);
    end
    // NMI ignores GIE; SP=0x0002 exercises address wrap
    INT = 1'b0; NMI = 1'b1; SP = 16'h0002; PC = 16'h1234; IntAddrLSBs = 6'd62;
    step();
    chk_all("n_push_pc", 1, 0, 16'h0000, 16'h1234, 1, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    NMI = 1'b0;
    step();
    chk_all("n_push_sr", 1, 0, 16'hFFFE, 16'h0000, 1, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    step();
    chk_all("n_ack", 1, 1, 16'h0, 16'h0, 0, 0, 0, 16'h0, 1, 16'h0000, 1, 16'hFFFE);
    step();
    chk_all("n_vec", 1, 0, 16'hFFFC, 16'h0, 0, 1, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    step();
    chk_all("n_load", 1, 0, 16'h0, 16'h0, 0, 0, 1, 16'h7000, 0, 16'h0, 0, 16'h0);
    step();
    chk_idle("n_idle");

    // late priority change: accepted with 45, winner is 52 at ACK
    SR = 16'h0008; SP = 16'h3000; PC = 16'h4500; IntAddrLSBs = 6'd45; INT = 1'b1;
    step();
    chk("late_busy", Busy, 1'b1);
    IntAddrLSBs = 6'd52; INT = 1'b0;
    step();
    step();
    chk("late_ack", INTACK, 1'b1);
    SR = 16'h0000;
    step();
    chk("late_vec_mab", MAB, 16'hFFE8);
    step();
    chk("late_pc_next", PC_next, 16'h5000);
    step();
    chk_idle("late_idle");

    // abort: reset asserted during PUSH_SR
    SR = 16'h0008; SP = 16'h3000; INT = 1'b1;
    step();
    chk("ab_push_pc_mw", MW, 1'b1);
    INT = 1'b0;
    step();
    chk("ab_push_sr_mab", MAB, 16'h2FFC);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("ab_hold", 1, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    end
    reset = 1'b0;
    step();
    chk_all("ab_rst_vec", 1, 1, 16'hFFFE, 16'h0, 0, 1, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    step();
    chk_all("ab_rst_load", 1, 0, 16'h0, 16'h0, 0, 0, 1, 16'h4400, 1, 16'h0000, 0, 16'h0);
    step();
    chk_idle("ab_idle");

    // boundary gating: request waits for InstrBoundary
    SR = 16'h0008; SP = 16'h3000; INT = 1'b1; InstrBoundary = 1'b0; IntAddrLSBs = 6'd45;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bg_wait_busy", Busy, 1'b0);
    end
    InstrBoundary = 1'b1;
    step();
    chk("bg_a1_busy", Busy, 1'b1);
    chk("bg_a1_intack", INTACK, 1'b0);
    INT = 1'b0;
    step();
    chk("bg_a2_intack", INTACK, 1'b0);
    step();
    chk("bg_a3_intack", INTACK, 1'b1);
    SR = 16'h0000;
    step();
    chk("bg_a4_intack", INTACK, 1'b0);
    chk("bg_vec_mab", MAB, 16'hFFDA);
    step();
    chk("bg_a5_busy", Busy, 1'b1);
    chk("bg_pc_next", PC_next, 16'h6000);
    step();
    chk("bg_a6_busy", Busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
